// File: rtl/pswd_pkg.sv
// Shared definitions for the password provisioning block: the FSM state
// encoding, field widths and the memory address calculation.
package pswd_pkg;

    localparam int DIGIT_W = 4;
    localparam int ADDR_W  = 5;
    localparam int USER_W  = 3;
    localparam int IDX_W   = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTER1 = 3'd1,
        ENTER2 = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    // Slot base plus digit index; anything above the 5-bit address space wraps.
    function automatic logic [ADDR_W-1:0] calc_addr(
        input logic [USER_W-1:0] user,
        input logic [IDX_W-1:0]  idx,
        input logic [3:0]        len
    );
        logic [7:0] full_s;
        full_s = ({5'd0, user} * {4'd0, len}) + {5'd0, idx};
        return full_s[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/pswd_edge_det.sv
// Two-flop rising-edge detector for the digit-entry button. The first flop
// registers the raw button, the second keeps one cycle of history, so a
// held button produces exactly one single-cycle pulse.
module pswd_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sync_r;
    logic prev_r;

    // Register the button and keep one cycle of history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= din;
            prev_r <= sync_r;
        end
    end

    assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/pswd_provision.sv
// Password change sequencer: accepts a change request from a logged-in
// session, takes the new password twice, and on a match writes it digit by
// digit into the password memory slot of the latched user.
// Optional feature: define PSWD_TIMEOUT_EN to abort entry after
// TIMEOUT_CYCLES cycles without a digit.
module pswd_provision
    import pswd_pkg::*;
#(
    parameter int          PSWD_LEN       = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Logged_In,
    input  logic                Change_Req,
    input  logic [USER_W-1:0]   User_Sel,
    input  logic                Password_Enter,
    input  logic [DIGIT_W-1:0]  Password,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DIGIT_W-1:0]  wr_data,
    output logic                Busy,
    output logic                Done,
    output logic                Error
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PSWD_LEN - 1);
    localparam logic [3:0]       LEN_4    = 4'(PSWD_LEN);

    if (PSWD_LEN < 1 || PSWD_LEN > 8) begin : g_len_chk
        $error("PSWD_LEN must be within 1..8");
    end
    if (TIMEOUT_CYCLES == 32'd0) begin : g_tmo_chk
        $error("TIMEOUT_CYCLES must be non-zero");
    end

    state_t               state_r, next_s;
    logic [IDX_W-1:0]     idx_r, idx_next_s;
    logic                 mism_r, mism_next_s;
    logic [USER_W-1:0]    user_r, user_next_s;
    logic [DIGIT_W-1:0]   buf_a_r [8];
    logic                 store_s;
    logic                 clear_s;
    logic                 digit_s;
    logic                 accept_s;
    logic                 in_enter_s;
    logic                 timeout_s;

    logic                 wr_en_r;
    logic [ADDR_W-1:0]    wr_addr_r;
    logic [DIGIT_W-1:0]   wr_data_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 error_r;

    pswd_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (Password_Enter),
        .rise (digit_s)
    );

    assign accept_s   = (state_r == IDLE) && Change_Req && Logged_In;
    assign in_enter_s = (state_r == ENTER1) || (state_r == ENTER2);

`ifdef PSWD_TIMEOUT_EN
    logic [31:0] tmo_cnt_r;

    // Inactivity counter: restarts on request acceptance and on every digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= 32'd0;
        end else if (accept_s || (in_enter_s && digit_s)) begin
            tmo_cnt_r <= 32'd0;
        end else if (in_enter_s) begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
        end else begin
            tmo_cnt_r <= 32'd0;
        end
    end

    assign timeout_s = in_enter_s && (tmo_cnt_r == (TIMEOUT_CYCLES - 32'd1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, index and buffer-control decisions
    always_comb begin
        next_s      = state_r;
        idx_next_s  = idx_r;
        mism_next_s = mism_r;
        user_next_s = user_r;
        store_s     = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_s      = ENTER1;
                    idx_next_s  = 3'd0;
                    mism_next_s = 1'b0;
                    user_next_s = User_Sel;
                end else begin
                    next_s = IDLE;
                end
            end
            ENTER1: begin
                if (!Logged_In || timeout_s) begin
                    next_s = ERR;
                end else if (digit_s) begin
                    store_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        idx_next_s = 3'd0;
                        next_s     = ENTER2;
                    end else begin
                        idx_next_s = idx_r + 3'd1;
                    end
                end else begin
                    next_s = ENTER1;
                end
            end
            ENTER2: begin
                if (!Logged_In || timeout_s) begin
                    next_s = ERR;
                end else if (digit_s) begin
                    if (idx_r == LAST_IDX) begin
                        idx_next_s = 3'd0;
                        if (mism_r || (Password != buf_a_r[idx_r])) begin
                            next_s = ERR;
                        end else begin
                            next_s = WRITE;
                        end
                    end else begin
                        idx_next_s = idx_r + 3'd1;
                        if (Password != buf_a_r[idx_r]) begin
                            mism_next_s = 1'b1;
                        end else begin
                            mism_next_s = mism_r;
                        end
                    end
                end else begin
                    next_s = ENTER2;
                end
            end
            WRITE: begin
                // Login loss is deliberately ignored here: never leave a partial password
                if (idx_r == LAST_IDX) begin
                    idx_next_s = 3'd0;
                    next_s     = DONE;
                end else begin
                    idx_next_s = idx_r + 3'd1;
                end
            end
            DONE, ERR: begin
                next_s      = IDLE;
                idx_next_s  = 3'd0;
                mism_next_s = 1'b0;
                clear_s     = 1'b1;
            end
            default: begin
                next_s      = IDLE;
                idx_next_s  = 3'd0;
                mism_next_s = 1'b0;
                clear_s     = 1'b1;
            end
        endcase
    end

    // State, index, mismatch flag and latched user slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= 3'd0;
            mism_r  <= 1'b0;
            user_r  <= 3'd0;
        end else begin
            state_r <= next_s;
            idx_r   <= idx_next_s;
            mism_r  <= mism_next_s;
            user_r  <= user_next_s;
        end
    end

    // First-entry digit buffer, wiped after every finished or aborted change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                buf_a_r[i] <= 4'd0;
            end
        end else if (clear_s) begin
            for (int i = 0; i < 8; i++) begin
                buf_a_r[i] <= 4'd0;
            end
        end else if (store_s) begin
            buf_a_r[idx_r] <= Password;
        end else begin
            buf_a_r[idx_r] <= buf_a_r[idx_r];
        end
    end

    // Outputs registered from the next state so they line up with the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= 5'd0;
            wr_data_r <= 4'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            busy_r  <= (next_s != IDLE);
            done_r  <= (next_s == DONE);
            error_r <= (next_s == ERR);
            if (next_s == WRITE) begin
                wr_en_r   <= 1'b1;
                wr_addr_r <= calc_addr(user_next_s, idx_next_s, LEN_4);
                wr_data_r <= buf_a_r[idx_next_s];
            end else begin
                wr_en_r   <= 1'b0;
                wr_addr_r <= 5'd0;
                wr_data_r <= 4'd0;
            end
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign Busy    = busy_r;
    assign Done    = done_r;
    assign Error   = error_r;

endmodule

// File: tb/tb_pswd_provision.sv
// Self-checking bench for pswd_provision: a table of directed password
// changes, randomized changes checked against a simple transaction model,
// and hand-written sequences for login loss, held button, reset mid-write
// and the inactivity timeout (both builds).
module tb_pswd_provision;

    localparam int LEN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       Logged_In;
    logic       Change_Req;
    logic [2:0] User_Sel;
    logic       Password_Enter;
    logic [3:0] Password;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [3:0] wr_data;
    logic       Busy;
    logic       Done;
    logic       Error;

    always #5 clk = ~clk;

    pswd_provision #(.PSWD_LEN(LEN), .TIMEOUT_CYCLES(32'd100)) dut (
        .clk            (clk),
        .rst            (rst),
        .Logged_In      (Logged_In),
        .Change_Req     (Change_Req),
        .User_Sel       (User_Sel),
        .Password_Enter (Password_Enter),
        .Password       (Password),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .Busy           (Busy),
        .Done           (Done),
        .Error          (Error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Output monitor, sampled on the falling edge
    int         cyc = 0;
    logic [4:0] q_addr[$];
    logic [3:0] q_data[$];
    int         q_cyc[$];
    int         done_n = 0;
    int         err_n = 0;
    int         err_cyc = 0;
    int         last_press_cyc = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr_en) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
            q_cyc.push_back(cyc);
        end
        if (Done) done_n = done_n + 1;
        if (Error) begin
            err_n   = err_n + 1;
            err_cyc = cyc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        done_n = 0;
        err_n  = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        Password       = d;
        Password_Enter = 1'b1;
        last_press_cyc = cyc;
        step(2);
        Password_Enter = 1'b0;
        step(2);
    endtask

    // Pulse a change request, then scramble User_Sel to prove it was latched
    task automatic request(input logic [2:0] u);
        User_Sel   = u;
        Change_Req = 1'b1;
        step(1);
        Change_Req = 1'b0;
        User_Sel   = u + 3'd3;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (Busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(Busy), 0);
        step(2);
    endtask

    // Model: a change succeeds iff both entries agree digit for digit; the
    // memory then receives digit i of the slot at user*LEN+i, in order.
    task automatic check_txn(input string tag, input logic [2:0] u,
                             input logic [15:0] a, input logic [15:0] b);
        bit ok;
        int nexp;
        logic [15:0] av;
        logic [3:0]  dg;
        av = a;
        ok = (a == b);
        nexp = ok ? LEN : 0;
        check({tag, ".nwr"}, q_addr.size(), nexp);
        for (int i = 0; i < LEN && i < q_addr.size(); i++) begin
            dg = av[4*i +: 4];
            check({tag, ".addr"}, int'(q_addr[i]), (int'(u) * LEN + i) % 32);
            check({tag, ".data"}, int'(q_data[i]), int'(dg));
            check({tag, ".cyc"}, q_cyc[i], last_press_cyc + 3 + i);
        end
        check({tag, ".done"}, done_n, ok ? 1 : 0);
        check({tag, ".err"}, err_n, ok ? 0 : 1);
        if (!ok) check({tag, ".errcyc"}, err_cyc, last_press_cyc + 3);
    endtask

    task automatic run_txn(input string tag, input logic [2:0] u,
                           input logic [15:0] a, input logic [15:0] b);
        logic [15:0] av;
        logic [15:0] bv;
        av = a;
        bv = b;
        clear_mon();
        request(u);
        for (int i = 0; i < LEN; i++) press(av[4*i +: 4]);
        for (int i = 0; i < LEN; i++) press(bv[4*i +: 4]);
        wait_idle({tag, ".idle"});
        check_txn(tag, u, a, b);
    endtask

    // Directed vectors; digit i of a password sits in bits [4i+3:4i]
    typedef struct {
        logic [2:0]  user;
        logic [15:0] first;
        logic [15:0] second;
        bit          exp_ok;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int k;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [2:0]  ru;
        int          pos;

        vecs[0] = '{3'd2, 16'h4321, 16'h4321, 1'b1};
        vecs[1] = '{3'd2, 16'h4321, 16'h5321, 1'b0};
        vecs[2] = '{3'd7, 16'hFA09, 16'hFA09, 1'b1};
        vecs[3] = '{3'd0, 16'h0000, 16'h0000, 1'b1};
        vecs[4] = '{3'd5, 16'h1111, 16'h1112, 1'b0};

        rst            = 1'b1;
        Logged_In      = 1'b0;
        Change_Req     = 1'b0;
        User_Sel       = 3'd0;
        Password_Enter = 1'b0;
        Password       = 4'd0;
        step(3);
        check("rst.wr_en", int'(wr_en), 0);
        check("rst.addr",  int'(wr_addr), 0);
        check("rst.data",  int'(wr_data), 0);
        check("rst.busy",  int'(Busy), 0);
        check("rst.done",  int'(Done), 0);
        check("rst.error", int'(Error), 0);
        rst = 1'b0;
        step(2);

        // Change request without a session
        clear_mon();
        request(3'd1);
        step(5);
        check("nolog.busy", int'(Busy), 0);
        check("nolog.nwr", q_addr.size(), 0);
        check("nolog.flags", done_n + err_n, 0);

        Logged_In = 1'b1;
        foreach (vecs[i]) begin
            run_txn($sformatf("vec%0d", i), vecs[i].user, vecs[i].first, vecs[i].second);
            check($sformatf("vec%0d.ok", i), done_n, int'(vecs[i].exp_ok));
        end

        // Randomized changes, half of them with one digit corrupted
        for (int n = 0; n < 16; n++) begin
            ru  = 3'($urandom_range(7, 0));
            ra  = 16'($urandom);
            rb  = ra;
            pos = $urandom_range(LEN - 1, 0);
            if ($urandom_range(1, 0) == 1) begin
                rb[4*pos +: 4] = ra[4*pos +: 4] ^ 4'($urandom_range(15, 1));
            end
            run_txn($sformatf("rnd%0d", n), ru, ra, rb);
        end

        // Held button gives a single digit
        clear_mon();
        request(3'd6);
        Password       = 4'd5;
        Password_Enter = 1'b1;
        step(20);
        Password_Enter = 1'b0;
        step(2);
        for (int i = 0; i < LEN - 1; i++) press(4'd5);
        for (int i = 0; i < LEN; i++) press(4'd5);
        wait_idle("held.idle");
        check_txn("held", 3'd6, 16'h5555, 16'h5555);

        // Change request while busy is ignored (slot stays the first one)
        clear_mon();
        request(3'd1);
        User_Sel   = 3'd4;
        Change_Req = 1'b1;
        press(4'd7);
        Change_Req = 1'b0;
        for (int i = 0; i < LEN - 1; i++) press(4'd7);
        for (int i = 0; i < LEN; i++) press(4'd7);
        wait_idle("busyreq.idle");
        check_txn("busyreq", 3'd1, 16'h7777, 16'h7777);

        // Session lost during first entry
        clear_mon();
        request(3'd3);
        press(4'd1);
        press(4'd2);
        Logged_In = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("logout.error", int'(Error), 1);
        step(1);
        Logged_In = 1'b1;
        wait_idle("logout.idle");
        check("logout.nwr", q_addr.size(), 0);
        check("logout.nerr", err_n, 1);

        // Reset in the middle of the write burst
        clear_mon();
        request(3'd2);
        for (int i = 0; i < LEN; i++) press(4'(i + 1));
        for (int i = 0; i < LEN - 1; i++) press(4'(i + 1));
        Password       = 4'd4;
        Password_Enter = 1'b1;
        k = 0;
        while (!wr_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rstwr.started", int'(wr_en), 1);
        Password_Enter = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rstwr.wr_en", int'(wr_en), 0);
        check("rstwr.busy", int'(Busy), 0);
        step(1);
        rst = 1'b0;
        clear_mon();
        step(10);
        check("rstwr.nwr", q_addr.size(), 0);
        check("rstwr.idle", int'(Busy), 0);

        // Inactivity behaviour
        clear_mon();
        request(3'd0);
`ifdef PSWD_TIMEOUT_EN
        k = 0;
        while (!Error && k < 150) begin
            @(negedge clk);
            k++;
        end
        check("tmo.error", int'(Error), 1);
        check("tmo.window", int'(k >= 99 && k <= 102), 1);
        wait_idle("tmo.idle");
`else
        step(200);
        check("tmo.busy200", int'(Busy), 1);
        check("tmo.noerr", err_n, 0);
        Logged_In = 1'b0;
        wait_idle("tmo.idle");
        Logged_In = 1'b1;
`endif
        check("tmo.nwr", q_addr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pswd_provision.md
PSWD_PROVISION -- requirements
Module: pswd_provision

Interface
REQ-001 Parameter PSWD_LEN, default 4: digits per password (1..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 32'd500_000_000: inactivity limit in cycles, used only with PSWD_TIMEOUT_EN.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 Logged_In  input  1  level; a session is authenticated.
REQ-006 Change_Req  input  1  level/pulse; request a password change.
REQ-007 User_Sel  input  3  user slot whose password is rewritten; latched at request acceptance.
REQ-008 Password_Enter  input  1  digit-entry button; one digit per rising edge.
REQ-009 Password  input  4  digit value, sampled on the cycle the Password_Enter rising edge is detected.
REQ-010 wr_en  output  1  password-memory write strobe.
REQ-011 wr_addr  output  5  write address = User_Sel*PSWD_LEN + digit index, truncated to 5 bits.
REQ-012 wr_data  output  4  digit written.
REQ-013 Busy  output  1  high in any state other than IDLE.
REQ-014 Done  output  1  one-cycle pulse: new password committed.
REQ-015 Error  output  1  one-cycle pulse: change aborted.

Function
REQ-016 FSM states SHALL be IDLE, ENTER1, ENTER2, WRITE, DONE, ERR.
REQ-017 IDLE->ENTER1 when Change_Req=1 and Logged_In=1; Change_Req with Logged_In=0 is ignored; User_Sel latched on this transition.
REQ-018 Password_Enter SHALL be registered once and rising-edge detected; a held button yields exactly one digit.
REQ-019 ENTER1 stores digits into buffer A, index 0..PSWD_LEN-1; after the PSWD_LEN-th digit, next state ENTER2 with index reset to 0.
REQ-020 ENTER2 compares each digit with buffer A[index] and records any mismatch; after the PSWD_LEN-th digit: all matched -> WRITE, otherwise -> ERR.
REQ-021 WRITE asserts wr_en for exactly PSWD_LEN consecutive cycles, index 0 first, then -> DONE.
REQ-022 DONE and ERR last one cycle each, pulse Done/Error, then -> IDLE; buffer A cleared to 0.
REQ-023 Logged_In falling to 0 in ENTER1 or ENTER2 -> ERR on the next cycle; in WRITE the write sequence completes (no partial password).
REQ-024 Change_Req while Busy is ignored.
REQ-025 Digit edges arriving in WRITE, DONE or ERR are discarded.
REQ-026 wr_en=0 outside WRITE; wr_addr/wr_data are don't-care while wr_en=0 but SHALL hold 0 in IDLE.

Reset
REQ-027 rst=1 forces IDLE immediately; outputs 0, buffers, index, edge-detect register and timeout counter cleared.
REQ-028 Reset during WRITE aborts writing; no further wr_en pulse after rst deasserts.

Configuration
REQ-029 Macro PSWD_TIMEOUT_EN defined: counter clears on every accepted digit and on entering ENTER1; reaching TIMEOUT_CYCLES in ENTER1/ENTER2 -> ERR.
REQ-030 PSWD_TIMEOUT_EN undefined: no counter logic; ENTER1/ENTER2 wait indefinitely.

Structure
REQ-031 Shared package pswd_pkg SHALL hold the state enumeration, digit width (4), address width (5) and user-select width (3).
REQ-032 Sub-module pswd_edge_det (2-flop rising-edge detector) SHALL be used for Password_Enter.

Verification
REQ-033 Logged_In=1, User_Sel=2, digits 1,2,3,4 then 1,2,3,4 -> wr_en 4 cycles, addr 8..11 with data 1..4, Done pulse, Busy low.
REQ-034 Digits 1,2,3,4 then 1,2,3,5 -> no wr_en, Error pulse one cycle after 4th confirm digit.
REQ-035 Change_Req with Logged_In=0 -> Busy stays 0, no outputs.
REQ-036 Password_Enter held high 20 cycles -> one digit accepted.
REQ-037 Logged_In drops after 2 first-entry digits -> Error next cycle; rst asserted mid-WRITE -> wr_en 0 immediately, state IDLE.
REQ-038 PSWD_TIMEOUT_EN, TIMEOUT_CYCLES=100, no digits after request -> Error at cycle 100; without macro, still Busy at cycle 200.
